ahb3_sram_bridge: RTL and testbench

- AHB-Lite slave that bridges to a single-port synchronous SRAM macro.
- Parametrised data width (32/64), memory size and SRAM read latency.
- Supports HSIZE byte-lane writes, pipelined zero-wait writes, latency-matched read wait states and two-cycle ERROR responses.
- Sits on the SoC AHB3 interconnect in front of on-chip scratchpad/boot SRAM.

---
 rtl/ahb3_sram_bridge.sv | 143 ++++++++++++++
 tb/tb_ahb3_sram_bridge.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3_sram_bridge.sv
// AHB-Lite slave in front of a single-port synchronous SRAM with configurable read latency.
// Define AHB3_SRAM_ALIGN_CHECK_EN to answer misaligned transfers with ERROR instead of aligning.
module ahb3_sram_bridge #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PLEN      = 32,
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned SW       = XLEN / 8,
  localparam int unsigned BYTE_AW  = $clog2(SW),
  localparam int unsigned MEM_AW   = $clog2(MEM_BYTES) - BYTE_AW
) (
  input  logic              ahb3_clk_i,
  input  logic              ahb3_rstn_i,
  input  logic              ahb3_hsel_i,
  input  logic [PLEN-1:0]   ahb3_haddr_i,
  input  logic [XLEN-1:0]   ahb3_hwdata_i,
  input  logic              ahb3_hwrite_i,
  input  logic [2:0]        ahb3_hsize_i,
  input  logic [2:0]        ahb3_hburst_i,
  input  logic [3:0]        ahb3_hprot_i,
  input  logic [1:0]        ahb3_htrans_i,
  input  logic              ahb3_hmastlock_i,
  input  logic              ahb3_hready_i,
  output logic [XLEN-1:0]   ahb3_hrdata_o,
  output logic              ahb3_hready_o,
  output logic              ahb3_hresp_o,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [SW-1:0]     sram_be,
  output logic [XLEN-1:0]   sram_din,
  input  logic [XLEN-1:0]   sram_dout
);

  localparam int unsigned MemAbits = $clog2(MEM_BYTES);
  localparam int unsigned CntW     = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              defer_q, defer_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [SW-1:0]     be_q, be_d;
  logic              hready_q, hready_d;
  logic              hresp_q, hresp_d;

  logic               accept, oor, size_err, misalign, addr_err, early_rd;
  logic [BYTE_AW-1:0] offset, size_mask;
  logic [31:0]        lanes;
  logic [SW-1:0]      be_req;
  logic [MEM_AW-1:0]  haddr_word;
  logic               unused_ok;

  assign unused_ok = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i};

  assign size_mask  = BYTE_AW'((32'd1 << ahb3_hsize_i) - 32'd1);
  assign size_err   = ahb3_hsize_i > 3'(BYTE_AW);
  assign haddr_word = ahb3_haddr_i[MemAbits-1:BYTE_AW];

`ifdef AHB3_SRAM_ALIGN_CHECK_EN
  assign offset   = ahb3_haddr_i[BYTE_AW-1:0];
  assign misalign = |(offset & size_mask);
`else
  // Low address bits below the transfer size are dropped, so every access is aligned.
  assign offset   = ahb3_haddr_i[BYTE_AW-1:0] & ~size_mask;
  assign misalign = 1'b0;
`endif

  if (PLEN > MemAbits) begin : g_oor
    assign oor = |ahb3_haddr_i[PLEN-1:MemAbits];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  assign lanes    = (32'd1 << (32'd1 << ahb3_hsize_i)) - 32'd1;
  assign be_req   = SW'(lanes << offset);
  assign addr_err = oor | size_err | misalign;

  assign accept = ahb3_rstn_i & ahb3_hsel_i & ahb3_hready_i & ahb3_htrans_i[1] & hready_q;
  // The SRAM port is busy with the write data phase in StWr, so reads defer by one cycle there.
  assign early_rd = accept & ~ahb3_hwrite_i & ~addr_err & (state_q != StWr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    defer_d = 1'b0;
    addr_d  = addr_q;
    be_d    = be_q;
    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (state_q == StRd && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end else if (accept) begin
      addr_d = haddr_word;
      be_d   = be_req;
      if (addr_err) begin
        state_d = StErr1;
      end else if (ahb3_hwrite_i) begin
        state_d = StWr;
      end else begin
        state_d = StRd;
        defer_d = (state_q == StWr);
        cnt_d   = (state_q == StWr) ? CntW'(RD_LAT) : CntW'(RD_LAT - 1);
      end
    end else begin
      state_d = StIdle;
    end
    hready_d = !((state_d == StErr1) || (state_d == StRd && cnt_d != '0));
    hresp_d  = (state_d == StErr1) || (state_d == StErr2);
  end

  always_ff @(posedge ahb3_clk_i) begin
    if (!ahb3_rstn_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      defer_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      defer_q  <= defer_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign sram_ce   = early_rd | (state_q == StWr) | ((state_q == StRd) & defer_q);
  assign sram_we   = (state_q == StWr);
  assign sram_addr = early_rd ? haddr_word : addr_q;
  assign sram_be   = sram_we ? be_q : '1;
  assign sram_din  = ahb3_hwdata_i;

  assign ahb3_hrdata_o = (state_q == StRd && cnt_q == '0) ? sram_dout : '0;
  assign ahb3_hready_o = hready_q;
  assign ahb3_hresp_o  = hresp_q;

endmodule

// File: tb/tb_ahb3_sram_bridge.sv
// Directed bench: three bridge instances (32b/lat1, 32b/lat3, 64b/lat1) on a shared bus.
module tb_ahb3_sram_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel_a, hsel_b, hsel_c;
  logic [31:0] haddr;
  logic [63:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  logic [31:0] hrdata_a, din_a, dout_a, hrdata_b, din_b, dout_b;
  logic [63:0] hrdata_c, din_c, dout_c;
  logic        hready_a, hresp_a, ce_a, we_a;
  logic        hready_b, hresp_b, ce_b, we_b;
  logic        hready_c, hresp_c, ce_c, we_c;
  logic [13:0] addr_a, addr_b;
  logic [12:0] addr_c;
  logic [3:0]  be_a, be_b;
  logic [7:0]  be_c;

  int checks = 0;
  int errors = 0;
  int waits;

  always #5 clk = ~clk;

  ahb3_sram_bridge #(.XLEN(32), .RD_LAT(1)) dut_a (
    .ahb3_clk_i(clk), .ahb3_rstn_i(rstn), .ahb3_hsel_i(hsel_a), .ahb3_haddr_i(haddr),
    .ahb3_hwdata_i(hwdata[31:0]), .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize),
    .ahb3_hburst_i(3'b000), .ahb3_hprot_i(4'b0011), .ahb3_htrans_i(htrans),
    .ahb3_hmastlock_i(1'b0), .ahb3_hready_i(hready_a), .ahb3_hrdata_o(hrdata_a),
    .ahb3_hready_o(hready_a), .ahb3_hresp_o(hresp_a), .sram_ce(ce_a), .sram_we(we_a),
    .sram_addr(addr_a), .sram_be(be_a), .sram_din(din_a), .sram_dout(dout_a));

  ahb3_sram_bridge #(.XLEN(32), .RD_LAT(3)) dut_b (
    .ahb3_clk_i(clk), .ahb3_rstn_i(rstn), .ahb3_hsel_i(hsel_b), .ahb3_haddr_i(haddr),
    .ahb3_hwdata_i(hwdata[31:0]), .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize),
    .ahb3_hburst_i(3'b000), .ahb3_hprot_i(4'b0011), .ahb3_htrans_i(htrans),
    .ahb3_hmastlock_i(1'b0), .ahb3_hready_i(hready_b), .ahb3_hrdata_o(hrdata_b),
    .ahb3_hready_o(hready_b), .ahb3_hresp_o(hresp_b), .sram_ce(ce_b), .sram_we(we_b),
    .sram_addr(addr_b), .sram_be(be_b), .sram_din(din_b), .sram_dout(dout_b));

  ahb3_sram_bridge #(.XLEN(64), .RD_LAT(1)) dut_c (
    .ahb3_clk_i(clk), .ahb3_rstn_i(rstn), .ahb3_hsel_i(hsel_c), .ahb3_haddr_i(haddr),
    .ahb3_hwdata_i(hwdata), .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize),
    .ahb3_hburst_i(3'b000), .ahb3_hprot_i(4'b0011), .ahb3_htrans_i(htrans),
    .ahb3_hmastlock_i(1'b0), .ahb3_hready_i(hready_c), .ahb3_hrdata_o(hrdata_c),
    .ahb3_hready_o(hready_c), .ahb3_hresp_o(hresp_c), .sram_ce(ce_c), .sram_we(we_c),
    .sram_addr(addr_c), .sram_be(be_c), .sram_din(din_c), .sram_dout(dout_c));

  // SRAM models: byte-masked writes, reads valid RD_LAT cycles after issue.
  logic [31:0] mem_a [16384];
  logic [31:0] mem_b [16384];
  logic [63:0] mem_c [8192];
  logic [31:0] d_b1, d_b2;

  always_ff @(posedge clk) begin
    if (ce_a && we_a) begin
      for (int i = 0; i < 4; i++) if (be_a[i]) mem_a[addr_a][8*i +: 8] <= din_a[8*i +: 8];
    end else if (ce_a) begin
      dout_a <= mem_a[addr_a];
    end
  end

  always_ff @(posedge clk) begin
    if (ce_b && we_b) begin
      for (int i = 0; i < 4; i++) if (be_b[i]) mem_b[addr_b][8*i +: 8] <= din_b[8*i +: 8];
    end
    d_b1   <= mem_b[addr_b];
    d_b2   <= d_b1;
    dout_b <= d_b2;
  end

  always_ff @(posedge clk) begin
    if (ce_c && we_c) begin
      for (int i = 0; i < 8; i++) if (be_c[i]) mem_c[addr_c][8*i +: 8] <= din_c[8*i +: 8];
    end else if (ce_c) begin
      dout_c <= mem_c[addr_c];
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    hsel_a = 1'b0; hsel_b = 1'b0; hsel_c = 1'b0;
    htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic bus_req(input int s, input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel_a = (s == 0); hsel_b = (s == 1); hsel_c = (s == 2);
    haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
  endtask

  task automatic test_reset();
    mid();
    checks++;
    if ({hready_a, hresp_a, ce_a, we_a} !== 4'b1000 || hrdata_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_a: rdy/resp/ce/we=%b hrdata=%h want 1000 0", {hready_a, hresp_a, ce_a, we_a}, hrdata_a);
    end
    checks++;
    if ({hready_b, hresp_b, ce_b, we_b} !== 4'b1000 || hrdata_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_b: rdy/resp/ce/we=%b hrdata=%h want 1000 0", {hready_b, hresp_b, ce_b, we_b}, hrdata_b);
    end
    checks++;
    if ({hready_c, hresp_c, ce_c, we_c} !== 4'b1000 || hrdata_c !== 64'h0) begin
      errors++;
      $display("FAIL reset_c: rdy/resp/ce/we=%b hrdata=%h want 1000 0", {hready_c, hresp_c, ce_c, we_c}, hrdata_c);
    end
    nxt();
  endtask

  task automatic test_write_read();
    bus_req(0, 32'h100, 1'b1, 3'd2);
    mid();
    checks++;
    if ({hready_a, ce_a} !== 2'b10) begin
      errors++; $display("FAIL wr_addr_phase: rdy/ce=%b want 10", {hready_a, ce_a});
    end
    nxt();
    hwdata = 64'hDEADBEEF;
    bus_req(0, 32'h100, 1'b0, 3'd2);
    mid();
    checks++;
    if ({ce_a, we_a, hready_a} !== 3'b111 || addr_a !== 14'h40 || be_a !== 4'hF || din_a !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_data_phase: ce/we/rdy=%b addr=%h be=%b din=%h want 111 40 1111 deadbeef", {ce_a, we_a, hready_a}, addr_a, be_a, din_a);
    end
    nxt();
    bus_idle();
    mid();
    checks++;
    if ({hready_a, ce_a, we_a} !== 3'b010 || addr_a !== 14'h40) begin
      errors++; $display("FAIL rd_deferred: rdy/ce/we=%b addr=%h want 010 40", {hready_a, ce_a, we_a}, addr_a);
    end
    nxt();
    mid();
    checks++;
    if ({hready_a, hresp_a} !== 2'b10 || hrdata_a !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data: rdy/resp=%b hrdata=%h want 10 deadbeef", {hready_a, hresp_a}, hrdata_a);
    end
    nxt();
  endtask

  task automatic test_byte_lanes();
    bus_req(0, 32'h103, 1'b1, 3'd0);
    nxt();
    hwdata = 64'hAA000000;
    bus_idle();
    mid();
    checks++;
    if ({ce_a, we_a} !== 2'b11 || be_a !== 4'b1000) begin
      errors++; $display("FAIL byte_be: ce/we=%b be=%b want 11 1000", {ce_a, we_a}, be_a);
    end
    nxt();
    bus_req(0, 32'h100, 1'b0, 3'd2);
    mid();
    checks++;
    if ({ce_a, we_a, hready_a} !== 3'b101 || addr_a !== 14'h40) begin
      errors++; $display("FAIL rd_early_issue: ce/we/rdy=%b addr=%h want 101 40", {ce_a, we_a, hready_a}, addr_a);
    end
    nxt();
    bus_idle();
    mid();
    checks++;
    if (hready_a !== 1'b1 || hrdata_a !== 32'hAAADBEEF) begin
      errors++; $display("FAIL byte_readback: rdy=%b hrdata=%h want 1 aaadbeef", hready_a, hrdata_a);
    end
    nxt();
  endtask

  task automatic test_align();
    bus_req(0, 32'h102, 1'b1, 3'd1);
    nxt();
    hwdata = 64'h55550000;
    bus_req(0, 32'h106, 1'b1, 3'd2);
    mid();
    checks++;
    if (be_a !== 4'b1100 || addr_a !== 14'h40 || hready_a !== 1'b1) begin
      errors++; $display("FAIL half_be: be=%b addr=%h rdy=%b want 1100 40 1", be_a, addr_a, hready_a);
    end
    nxt();
    hwdata = 64'h11223344;
    bus_idle();
    mid();
    checks++;
    if (be_a !== 4'hF || addr_a !== 14'h41 || {hready_a, hresp_a} !== 2'b10) begin
      errors++; $display("FAIL misaligned_forced: be=%b addr=%h rdy/resp=%b want 1111 41 10", be_a, addr_a, {hready_a, hresp_a});
    end
    nxt();
  endtask

  task automatic test_idle_busy();
    hsel_a = 1'b1; haddr = 32'h100; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b01;
    mid();
    checks++;
    if ({ce_a, hready_a, hresp_a} !== 3'b010) begin
      errors++; $display("FAIL busy_no_access: ce/rdy/resp=%b want 010", {ce_a, hready_a, hresp_a});
    end
    nxt();
    hsel_a = 1'b0; hwrite = 1'b0; htrans = 2'b10;
    mid();
    checks++;
    if (ce_a !== 1'b0) begin
      errors++; $display("FAIL unselected_no_access: ce=%b want 0", ce_a);
    end
    nxt();
    bus_idle();
    mid();
    checks++;
    if ({hready_a, hresp_a} !== 2'b10 || hrdata_a !== 32'h0) begin
      errors++; $display("FAIL unselected_response: rdy/resp=%b hrdata=%h want 10 0", {hready_a, hresp_a}, hrdata_a);
    end
    nxt();
  endtask

  task automatic test_error();
    bus_req(0, 32'h0001_0000, 1'b0, 3'd2);
    mid();
    checks++;
    if ({ce_a, hready_a} !== 2'b01) begin
      errors++; $display("FAIL oor_addr_phase: ce/rdy=%b want 01", {ce_a, hready_a});
    end
    nxt();
    bus_idle();
    mid();
    checks++;
    if ({hready_a, hresp_a, ce_a} !== 3'b010) begin
      errors++; $display("FAIL err1: rdy/resp/ce=%b want 010", {hready_a, hresp_a, ce_a});
    end
    nxt();
    bus_req(0, 32'h100, 1'b0, 3'd2);
    mid();
    checks++;
    if ({hready_a, hresp_a, ce_a, we_a} !== 4'b1110) begin
      errors++; $display("FAIL err2_accept: rdy/resp/ce/we=%b want 1110", {hready_a, hresp_a, ce_a, we_a});
    end
    nxt();
    bus_idle();
    mid();
    checks++;
    if ({hready_a, hresp_a} !== 2'b10 || hrdata_a !== 32'h5555BEEF) begin
      errors++; $display("FAIL after_err_read: rdy/resp=%b hrdata=%h want 10 5555beef", {hready_a, hresp_a}, hrdata_a);
    end
    nxt();
  endtask

  task automatic test_latency();
    bus_req(1, 32'h200, 1'b1, 3'd2);
    nxt();
    hwdata = 64'h12345678;
    bus_req(1, 32'h200, 1'b0, 3'd2);
    mid();
    checks++;
    if ({ce_b, we_b, hready_b} !== 3'b111) begin
      errors++; $display("FAIL lat3_write: ce/we/rdy=%b want 111", {ce_b, we_b, hready_b});
    end
    nxt();
    bus_idle();
    waits = 0;
    mid();
    checks++;
    if ({ce_b, we_b} !== 2'b10) begin
      errors++; $display("FAIL lat3_deferred_issue: ce/we=%b want 10", {ce_b, we_b});
    end
    while (hready_b !== 1'b1 && waits < 10) begin
      waits++; nxt(); mid();
    end
    checks++;
    if (waits != 3 || hrdata_b !== 32'h12345678 || hresp_b !== 1'b0) begin
      errors++; $display("FAIL lat3_after_write: waits=%0d hrdata=%h resp=%b want 3 12345678 0", waits, hrdata_b, hresp_b);
    end
    // Next address phase overlaps the final data-phase cycle.
    bus_req(1, 32'h200, 1'b0, 3'd2);
    #1;
    checks++;
    if ({ce_b, we_b} !== 2'b10) begin
      errors++; $display("FAIL lat3_b2b_issue: ce/we=%b want 10", {ce_b, we_b});
    end
    nxt();
    bus_idle();
    waits = 0;
    mid();
    while (hready_b !== 1'b1 && waits < 10) begin
      waits++; nxt(); mid();
    end
    checks++;
    if (waits != 2 || hrdata_b !== 32'h12345678) begin
      errors++; $display("FAIL lat3_idle_port: waits=%0d hrdata=%h want 2 12345678", waits, hrdata_b);
    end
    nxt();
  endtask

  task automatic test_wide();
    bus_req(2, 32'h8, 1'b1, 3'd3);
    nxt();
    hwdata = 64'h0123456789ABCDEF;
    bus_req(2, 32'h8, 1'b0, 3'd3);
    mid();
    checks++;
    if ({ce_c, we_c} !== 2'b11 || be_c !== 8'hFF || addr_c !== 13'h1 || din_c !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL wide_write: ce/we=%b be=%h addr=%h din=%h want 11 ff 1 0123456789abcdef", {ce_c, we_c}, be_c, addr_c, din_c);
    end
    nxt();
    bus_idle();
    mid();
    checks++;
    if (hready_c !== 1'b0) begin
      errors++; $display("FAIL wide_wait: rdy=%b want 0", hready_c);
    end
    nxt();
    mid();
    checks++;
    if (hready_c !== 1'b1 || hrdata_c !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL wide_read: rdy=%b hrdata=%h want 1 0123456789abcdef", hready_c, hrdata_c);
    end
    bus_req(2, 32'h8, 1'b1, 3'd4);
    nxt();
    bus_idle();
    mid();
    checks++;
    if ({hready_c, hresp_c, ce_c} !== 3'b010) begin
      errors++; $display("FAIL hsize4_err1: rdy/resp/ce=%b want 010", {hready_c, hresp_c, ce_c});
    end
    nxt();
    mid();
    checks++;
    if ({hready_c, hresp_c, ce_c} !== 3'b110) begin
      errors++; $display("FAIL hsize4_err2: rdy/resp/ce=%b want 110", {hready_c, hresp_c, ce_c});
    end
    nxt();
    mid();
    checks++;
    if ({hready_c, hresp_c} !== 2'b10) begin
      errors++; $display("FAIL hsize4_done: rdy/resp=%b want 10", {hready_c, hresp_c});
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    bus_req(1, 32'h200, 1'b0, 3'd2);
    nxt();
    bus_idle();
    mid();
    checks++;
    if (hready_b !== 1'b0) begin
      errors++; $display("FAIL rst_pre_wait: rdy=%b want 0", hready_b);
    end
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
    mid();
    checks++;
    if ({hready_b, hresp_b, ce_b} !== 3'b100 || hrdata_b !== 32'h0) begin
      errors++; $display("FAIL rst_mid_read: rdy/resp/ce=%b hrdata=%h want 100 0", {hready_b, hresp_b, ce_b}, hrdata_b);
    end
    nxt();
    nxt();
    mid();
    checks++;
    if (hready_b !== 1'b1 || hrdata_b !== 32'h0) begin
      errors++; $display("FAIL rst_read_dropped: rdy=%b hrdata=%h want 1 0", hready_b, hrdata_b);
    end
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    haddr = '0; hwdata = '0; hsize = 3'd2;
    bus_idle();
    nxt();
    nxt();
    rstn = 1'b1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_align();
    test_idle_busy();
    test_error();
    test_latency();
    test_wide();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
